// File: rtl/data_mem_seq_pkg.sv
// data_mem_seq_pkg: shared types and constants for the byte-serial data-memory sequencer
package data_mem_seq_pkg;
    typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} seq_state_t;
    localparam int BYTES_PER_WORD = 4;
    typedef logic [1:0] byte_idx_t;
    typedef logic [0:BYTES_PER_WORD-1][7:0] word_t;
endpackage

// File: rtl/data_mem_seq_if.sv
// data_mem_seq_if: byte-wide handshaked memory bus between sequencer (master) and memory (slave)
interface data_mem_seq_if #(parameter int ADDR_W = 16) ();
    logic              req;
    logic              we;
    logic              ack;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wdata;
    logic [7:0]        rdata;
    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/data_mem_seq_timer.sv
// mem_seq_timer: per-byte wait counter that flags when TIMEOUT-1 idle cycles have elapsed
module mem_seq_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    logic [W-1:0] cnt;
    always_ff @(posedge clk)
        cnt <= (rst || clr) ? '0 : cnt + W'(en);
    assign expired = cnt == W'(TIMEOUT - 1);
endmodule

// File: rtl/data_mem_seq.sv
// data_mem_seq: splits each core word access into four big-endian byte transfers on a handshaked bus
module data_mem_seq
    import data_mem_seq_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic [31:0]           mem_addr,
    input  logic                  mem_read_en,
    input  logic                  mem_write_en,
    input  word_t                 mem_data_in,
    output word_t                 mem_data_out,
    output logic                  stall,
    input  logic                  halted,
    data_mem_seq_if.master        bm,
    output logic                  err
);
    localparam logic [1:0] IDLE = S_IDLE;
    localparam logic [1:0] XFER = S_XFER;
    localparam logic [1:0] DONE = S_DONE;

    logic [1:0]        state;
    byte_idx_t         idx;
    logic              op;
    logic [ADDR_W-1:0] base;
    word_t             wbuf;
    word_t             rdbuf;
    word_t             rd_next;
    logic              start;
    logic              expired;
    logic              abort;
    logic              unused;

    assign unused   = ^{mem_addr[31:ADDR_W], mem_addr[1:0]};
    assign start    = (mem_read_en || mem_write_en) && !halted;
    assign stall    = start && state != DONE;
    assign bm.req   = state == XFER;
    assign bm.we    = bm.req && op;
    assign bm.addr  = base + ADDR_W'(idx);
    assign bm.wdata = wbuf[idx];
    assign abort    = bm.req && !bm.ack && expired;

    mem_seq_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst_b),
        .clr     (state != XFER || bm.ack),
        .en      (state == XFER),
        .expired (expired)
    );

    // On abort, every byte not yet received reads back as 8'hFF
    always_comb begin
        rd_next = rdbuf;
        if (bm.req && !op && bm.ack)
            rd_next[idx] = bm.rdata;
        else if (!op && abort)
            for (int i = 0; i < BYTES_PER_WORD; i++)
                rd_next[i] = i >= int'(idx) ? 8'hFF : rdbuf[i];
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state        <= IDLE;
            idx          <= '0;
            op           <= 1'b0;
            base         <= '0;
            wbuf         <= '0;
            rdbuf        <= '0;
            mem_data_out <= '0;
            err          <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    base  <= {mem_addr[ADDR_W-1:2], 2'b00};
                    op    <= mem_write_en;
                    wbuf  <= mem_data_in;
                    idx   <= '0;
                    state <= XFER;
                end
                XFER: begin
                    rdbuf <= rd_next;
                    idx   <= idx + byte_idx_t'(bm.ack);
                    if ((bm.ack && idx == 2'd3) || abort) begin
                        state        <= DONE;
                        mem_data_out <= rd_next;
                    end
                    if (abort)
                        err <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/data_mem_seq.md
# data_mem_seq

Multi-cycle data-memory sequencer between the single-cycle MIPS core's data port and a byte-wide, handshaked data memory. Each word access (`lw`/`sw`) is split into four big-endian byte transfers: byte 0 is the MSB at the word's lowest address. While the access is in flight the block holds the core with `stall`, then presents the assembled word for exactly one cycle.

## Interface
Parameters:
- `ADDR_W`, 16: byte-address width on the memory side.
- `TIMEOUT`, 64: maximum cycles to wait for `bm_ack` on one byte before aborting.

Ports:
- `clk`, in, 1: clock, rising-edge.
- `rst_b`, in, 1: reset. One clock; reset is synchronous and active-high (`rst_b`=1 resets).
- `mem_addr`, in, 32: core byte address. Bits [1:0] are ignored (forced to 0).
- `mem_read_en`, in, 1: core load request.
- `mem_write_en`, in, 1: core store request.
- `mem_data_in`, in, 4x8 (`[0:3]`): store data; [0] is the MSB.
- `mem_data_out`, out, 4x8 (`[0:3]`): load data; [0] is the MSB.
- `stall`, out, 1: core must not advance PC or commit writeback.
- `halted`, in, 1: core halted; no new requests are accepted.
- `bm_req`, out, 1: byte request valid.
- `bm_we`, out, 1: byte write.
- `bm_addr`, out, `ADDR_W`: byte address.
- `bm_wdata`, out, 8: write byte.
- `bm_ack`, in, 1: memory accepts/completes the current byte. May be combinational from `bm_req`.
- `bm_rdata`, in, 8: read byte, valid when `bm_ack`=1.
- `err`, out, 1: sticky timeout flag.

## Operation
- States: IDLE, XFER, DONE.
- IDLE:
  - If (`mem_read_en`|`mem_write_en`) & !`halted`: at the edge, latch base address {`mem_addr`[ADDR_W-1:2], 2'b00}, the op, and the four write bytes; clear byte index and timer; go to XFER.
  - If both enables are high, the access is a write.
- XFER:
  - `bm_req`=1, `bm_addr`=base+idx, `bm_we`=op, `bm_wdata`=wbyte[idx]. The memory is addressed with `ADDR_W` bits only; upper address bits are dropped.
  - On an edge with `bm_ack`=1: for a read, capture rdbuf[idx]=`bm_rdata`; reset the timer; if idx==3 go to DONE, else idx+1.
  - `bm_req` stays high across consecutive bytes with no bubble.
  - Timer increments each cycle without `bm_ack`. When it reaches `TIMEOUT`-1 without ack: set `err`, fill unreceived read bytes with 8'hFF, go to DONE.
- DONE: lasts one cycle, `stall`=0, `mem_data_out`=rdbuf. Always goes to IDLE next.
- `stall` is combinational: (`mem_read_en`|`mem_write_en`) & !`halted` & state!=DONE.
- `mem_data_out` holds its last value outside DONE.
- `halted` asserted mid-transfer: the transfer completes normally.
- Inputs changing during XFER are ignored; only latched values are used.

## Timing
- Reset values: state IDLE, `bm_req`=0, `bm_we`=0, `bm_addr`=0, `bm_wdata`=0, `mem_data_out`=all 0, `err`=0. `stall` follows its equation, so it is 0 with no request.
- Reset mid-transfer: at the reset edge, `bm_req` drops and the partial access is abandoned. No byte is retried.
- Zero-wait memory (ack in the same cycle as req): request seen in cycle T0, XFER T1–T4, DONE T5. `stall`=1 for T0–T4; the core commits at the end of T5. That is 6 cycles per access.
- Each wait cycle on a byte adds one cycle.
- A back-to-back request in the cycle after DONE is accepted normally.

## Structure
- Package `data_mem_seq_pkg`:
  - state enum `seq_state_t`.
  - `BYTES_PER_WORD`=4.
  - byte-index type `logic [1:0]`.
- Natural sub-module: `mem_seq_timer`, a per-byte wait counter with clear/enable inputs and an `expired` output, sized to cover `TIMEOUT`.
- Everything else is in one module.

## Test plan
- Zero-wait load: memory has 0x100..0x103 = 12 34 56 78; `mem_read_en`, `mem_addr`=0x102 → `bm_addr` 0x100..0x103 in order, `stall` high 5 cycles, `mem_data_out`={12,34,56,78} in DONE.
- Store with waits: data {DE,AD,BE,EF} to 0x20, ack after 2 wait cycles per byte → writes DE@0x20 … EF@0x23, `stall` high 13 cycles, `err`=0.
- Both enables high at 0x40 → four writes, no read data captured.
- Timeout with `TIMEOUT`=8 and no ack → `err`=1 after 8 cycles on byte 0, read returns {FF,FF,FF,FF}, `err` stays 1 until reset.
- Reset asserted during byte 2 → next cycle `bm_req`=0, state IDLE, `mem_data_out`=0; a new load then completes normally.
- `halted`=1 with `mem_read_en`=1 in IDLE → no `bm_req`, `stall`=0.
